jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
//
// PURPOSE
//   Drives an external WIDTH-bit bank of JK flip-flops to a requested target word.
//   Each target is accepted over a valid/ready handshake.
//   The block derives the per-bit J/K drive from a shadow copy of the bank state using the
//   JK excitation table, which inverts the flip-flop's next-state function.
//   It pulses the drive for exactly one clock, then reads back the bank's q outputs to
//   confirm the update and flags any mismatch.
//   Sits between sequencing/control logic and any register built from JK flip-flops.
//
// PARAMETERS
//   WIDTH       8   number of JK flip-flops in the driven bank
//   USE_TOGGLE  0   0: set/reset encoding for changed bits; 1: toggle (J=K=1) encoding
//   CHECK_EN    1   1: compare readback and report mismatches; 0: readback ignored
//
// PORTS
//   clk        in   1      clock; bank and driver share it, rising edge
//   rst        in   1      synchronous, active-high reset; must also reset the bank (q=0)
//   tgt_valid  in   1      target word offered
//   tgt_ready  out  1      driver can accept a target (IDLE only)
//   tgt_data   in   WIDTH  requested bank value, sampled on handshake
//   j_out      out  WIDTH  J inputs to the bank, registered
//   k_out      out  WIDTH  K inputs to the bank, registered
//   q_fb       in   WIDTH  q outputs of the bank (readback)
//   busy       out  1      high in DRIVE and CHECK
//   done       out  1      one-cycle pulse at the end of each update (CHECK state)
//   mismatch   out  1      one-cycle pulse with done when q_fb != target (CHECK_EN=1)
//   err_count  out  8      count of mismatches, saturates at 255
//
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE; shadow, j_out, k_out = 0; done, mismatch,
//     busy = 0; err_count=0; tgt_ready=1 after reset.
//   Reset wins over every other event, including mid-DRIVE or mid-CHECK. Any captured
//     target is discarded.
//   FSM states are IDLE, DRIVE and CHECK. Each state lasts one cycle except IDLE.
//   IDLE: tgt_ready=1 and j_out=k_out=0 (bank holds).
//     On tgt_valid&&tgt_ready: capture tgt_data into tgt_r, load j_out/k_out = excite(shadow, tgt_data),
//     and go to DRIVE.
//   DRIVE: j_out/k_out are stable for the whole cycle, and the bank samples them at the closing edge.
//     At that edge j_out/k_out clear to 0 and the FSM goes to CHECK.
//   CHECK: q_fb now reflects the update. done=1.
//     If CHECK_EN=1 and q_fb != tgt_r: mismatch=1, err_count += 1 (saturating), and shadow <= q_fb
//       so the next excitation is computed from the true bank state.
//     Otherwise shadow <= tgt_r.
//     Go to IDLE.
//   excite(), per bit (cur, tgt) -> (J, K):
//     0->0: (0,0).
//     1->1: (0,0).
//     0->1: (1,0), or (1,1) if USE_TOGGLE.
//     1->0: (0,1), or (1,1) if USE_TOGGLE.
//     Bits that do not change are never driven, so unchanged bits always hold.
//   Latency: handshake edge -> done pulse is 2 cycles. Throughput is one target per 3 cycles.
//   A target equal to shadow still traverses DRIVE/CHECK (all-hold drive) for uniform latency.
//   tgt_ready=0 in DRIVE/CHECK; tgt_valid there is ignored and not captured.
//   Changes on tgt_data after the handshake have no effect.
//   err_count at 255 stays 255. mismatch still pulses.
//   CHECK_EN=0: mismatch is never asserted and err_count stays 0.
//   j_out and k_out are never both 1 when USE_TOGGLE=0.
//
// TESTING
//   Bench instantiates a real JK bank (hold/reset/set/toggle, sync rst -> q=0) on j_out/k_out/q_fb.
//   1. Reset, then send 0xA5 -> j_out=0xA5, k_out=0x00 in DRIVE; done 2 cycles after the
//      handshake; q_fb=0xA5; mismatch=0.
//   2. From 0xA5 send 0x3C, USE_TOGGLE=0 -> j=0x18, k=0x81; q_fb=0x3C.
//      Repeat with USE_TOGGLE=1 -> j=k=0x99.
//   3. Force q_fb bit0 stuck at 0 and send 0x01 -> mismatch=1, err_count=1.
//      Then send 0x01 again -> j=0x01 (shadow resynced to q_fb).
//   4. Hold tgt_valid high with data 0x11, 0x22, 0x33 presented back-to-back -> each accepted only in IDLE.
//      Handshakes are 3 cycles apart; the bank ends at 0x33.
//   5. Assert rst during DRIVE -> next cycle IDLE; j_out=k_out=0; bank q=0; err_count=0; no done pulse.
//   6. Inject 256 mismatches -> err_count saturates at 255, and mismatch pulses on each.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Drives a bank of JK flip-flops to a requested word using the excitation table.
// After a one-cycle drive pulse it reads the bank back and reports any mismatch.
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter bit USE_TOGGLE = 1'b0,
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic             accept;
  logic             readback_bad;

  assign accept       = tgt_valid && (state == IDLE);
  assign readback_bad = CHECK_EN && (q_fb != tgt_r);

  // Only bits that differ from the shadow are driven; everything else holds.
  assign changed = shadow ^ tgt_data;
  assign j_next  = USE_TOGGLE ? changed : (changed & tgt_data);
  assign k_next  = USE_TOGGLE ? changed : (changed & ~tgt_data);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == CHECK);
    mismatch  = (state == CHECK) && readback_bad;
  end

  // The drive is registered so the bank sees a clean one-cycle pulse during DRIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      tgt_r     <= '0;
      j_out     <= '0;
      k_out     <= '0;
      err_count <= 8'd0;
    end else begin
      j_out <= '0;
      k_out <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_r <= tgt_data;
            j_out <= j_next;
            k_out <= k_next;
          end
        end
        CHECK: begin
          if (readback_bad) begin
            shadow <= q_fb;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            shadow <= tgt_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: three driver configurations, each on its own JK bank, checked every cycle
// against a transaction-level model, plus hand-computed directed expectations.
module tb_jk_excitation_driver;

  localparam int W = 8;
  localparam int N = 3;

  // Instance configurations: 0 set/reset, 1 toggle, 2 readback ignored.
  localparam bit CFG_TOG [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit CFG_CHK [N] = '{1'b1, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic [W-1:0] mask = '0;

  logic [W-1:0] j_o   [N];
  logic [W-1:0] k_o   [N];
  logic [W-1:0] q_fb  [N];
  logic [W-1:0] bank  [N];
  logic [7:0]   err_o [N];
  logic         rdy    [N];
  logic         busy_o [N];
  logic         done_o [N];
  logic         mm_o   [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_excitation_driver #(.WIDTH(W), .USE_TOGGLE(1'b0), .CHECK_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy[0]), .tgt_data(tgt_data),
    .j_out(j_o[0]), .k_out(k_o[0]), .q_fb(q_fb[0]), .busy(busy_o[0]), .done(done_o[0]),
    .mismatch(mm_o[0]), .err_count(err_o[0]));

  jk_excitation_driver #(.WIDTH(W), .USE_TOGGLE(1'b1), .CHECK_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy[1]), .tgt_data(tgt_data),
    .j_out(j_o[1]), .k_out(k_o[1]), .q_fb(q_fb[1]), .busy(busy_o[1]), .done(done_o[1]),
    .mismatch(mm_o[1]), .err_count(err_o[1]));

  jk_excitation_driver #(.WIDTH(W), .USE_TOGGLE(1'b0), .CHECK_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy[2]), .tgt_data(tgt_data),
    .j_out(j_o[2]), .k_out(k_o[2]), .q_fb(q_fb[2]), .busy(busy_o[2]), .done(done_o[2]),
    .mismatch(mm_o[2]), .err_count(err_o[2]));

  // Real JK banks; the mask forces readback bits stuck at 0.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      bank[i] <= rst ? '0 : ((j_o[i] & ~bank[i]) | (~k_o[i] & bank[i]));
  end

  always_comb begin
    for (int i = 0; i < N; i++) q_fb[i] = bank[i] & ~mask;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic void excite(input logic [W-1:0] cur, input logic [W-1:0] tgt, input bit tog,
                                 output logic [W-1:0] j, output logic [W-1:0] k);
    for (int b = 0; b < W; b++) begin
      case ({cur[b], tgt[b]})
        2'b01:   begin j[b] = 1'b1; k[b] = tog;  end
        2'b10:   begin j[b] = tog;  k[b] = 1'b1; end
        default: begin j[b] = 1'b0; k[b] = 1'b0; end
      endcase
    end
  endfunction

  function automatic logic [W-1:0] jk_step(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      case ({j[b], k[b]})
        2'b00: r[b] = q[b];
        2'b01: r[b] = 1'b0;
        2'b10: r[b] = 1'b1;
        2'b11: r[b] = ~q[b];
      endcase
    end
    return r;
  endfunction

  // m_age: cycles since the handshake (0 = waiting for a target).
  int           m_age    [N];
  int           m_err    [N];
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_tgt    [N];
  logic [W-1:0] m_bank   [N];
  logic [W-1:0] m_j      [N];
  logic [W-1:0] m_k      [N];
  bit           model_ok = 1'b0;
  logic [W-1:0] t_nb;
  logic [W-1:0] t_rb;

  always @(posedge clk) begin
    if (rst) model_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_age[i] = 0; m_err[i] = 0; m_shadow[i] = '0; m_tgt[i] = '0;
        m_bank[i] = '0; m_j[i] = '0; m_k[i] = '0;
      end else begin
        t_nb = jk_step(m_bank[i], m_j[i], m_k[i]);
        t_rb = m_bank[i] & ~mask;
        case (m_age[i])
          0: if (tgt_valid) begin
            m_tgt[i] = tgt_data;
            excite(m_shadow[i], tgt_data, CFG_TOG[i], m_j[i], m_k[i]);
            m_age[i] = 1;
          end
          1: begin m_j[i] = '0; m_k[i] = '0; m_age[i] = 2; end
          default: begin
            if (CFG_CHK[i] && t_rb != m_tgt[i]) begin
              if (m_err[i] < 255) m_err[i]++;
              m_shadow[i] = t_rb;
            end else begin
              m_shadow[i] = m_tgt[i];
            end
            m_age[i] = 0;
          end
        endcase
        m_bank[i] = t_nb;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("u%0d_ready", i), 32'(rdy[i]),    32'(m_age[i] == 0));
        check($sformatf("u%0d_busy", i),  32'(busy_o[i]), 32'(m_age[i] != 0));
        check($sformatf("u%0d_done", i),  32'(done_o[i]), 32'(m_age[i] == 2));
        check($sformatf("u%0d_mismatch", i), 32'(mm_o[i]),
              32'(m_age[i] == 2 && CFG_CHK[i] && (m_bank[i] & ~mask) != m_tgt[i]));
        check($sformatf("u%0d_j", i),   32'(j_o[i]),   32'(m_j[i]));
        check($sformatf("u%0d_k", i),   32'(k_o[i]),   32'(m_k[i]));
        check($sformatf("u%0d_err", i), 32'(err_o[i]), 32'(m_err[i]));
        check($sformatf("u%0d_q", i),   32'(bank[i]),  32'(m_bank[i]));
      end
    end
  end

  bit count_en = 1'b0;
  int mm_pulses = 0;
  always @(negedge clk) if (count_en && mm_o[0]) mm_pulses++;

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offers d and returns one step after the handshake edge (DRIVE cycle).
  task automatic send(input logic [W-1:0] d, input bit keep);
    bit hs = 1'b0;
    tgt_valid = 1'b1;
    tgt_data  = d;
    for (int n = 0; n < 12 && !hs; n++) begin
      @(negedge clk);
      if (rdy[0]) hs = 1'b1;
      tick();
    end
    if (!hs) check("handshake_timeout", 32'd0, 32'd1);
    if (!keep) begin
      tgt_valid = 1'b0;
      tgt_data  = W'($urandom);
    end
  endtask

  int t1, t2, t3;

  initial begin
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 32'd1);
    check("rst_busy",  32'(busy_o[0]), 32'd0);
    check("rst_jk",    32'({j_o[0], k_o[0]}), 32'd0);
    check("rst_err",   32'(err_o[0]), 32'd0);

    // Basic update from reset.
    tick();
    send(8'hA5, 1'b0);
    @(negedge clk);
    check("a5_j", 32'(j_o[0]), 32'hA5);
    check("a5_k", 32'(k_o[0]), 32'h00);
    check("a5_tog_jk", 32'({j_o[1], k_o[1]}), 32'hA5A5);
    @(negedge clk);
    check("a5_done", 32'(done_o[0]), 32'd1);
    check("a5_q",    32'(q_fb[0]), 32'hA5);
    check("a5_mm",   32'(mm_o[0]), 32'd0);

    // Set/reset versus toggle encoding.
    send(8'h3C, 1'b0);
    @(negedge clk);
    check("3c_j", 32'(j_o[0]), 32'h18);
    check("3c_k", 32'(k_o[0]), 32'h81);
    check("3c_tog_jk", 32'({j_o[1], k_o[1]}), 32'h9999);
    @(negedge clk);
    check("3c_q", 32'(q_fb[0]), 32'h3C);
    check("3c_tog_q", 32'(q_fb[1]), 32'h3C);

    // Readback bit0 stuck at 0.
    tick();
    mask = 8'h01;
    send(8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("stuck_mm", 32'(mm_o[0]), 32'd1);
    @(negedge clk);
    check("stuck_err", 32'(err_o[0]), 32'd1);
    send(8'h01, 1'b0);
    @(negedge clk);
    check("resync_j", 32'(j_o[0]), 32'h01);
    tick(); tick();
    mask = 8'h00;

    // Back-to-back offers with valid held high.
    send(8'h11, 1'b1); t1 = cyc;
    send(8'h22, 1'b1); t2 = cyc;
    send(8'h33, 1'b0); t3 = cyc;
    check("b2b_gap1", 32'(t2 - t1), 32'd3);
    check("b2b_gap2", 32'(t3 - t2), 32'd3);
    tick(); tick();
    @(negedge clk);
    check("b2b_q",     32'(bank[0]), 32'h33);
    check("b2b_tog_q", 32'(bank[1]), 32'h33);

    // Reset in the middle of DRIVE.
    tick();
    send(8'h5A, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(rdy[0]), 32'd1);
    check("mid_rst_jk",    32'({j_o[0], k_o[0]}), 32'd0);
    check("mid_rst_q",     32'(bank[0]), 32'd0);
    check("mid_rst_err",   32'(err_o[0]), 32'd0);
    check("mid_rst_done",  32'(done_o[0]), 32'd0);
    @(negedge clk);
    check("mid_rst_done2", 32'(done_o[0]), 32'd0);

    // Saturation: every readback reads 0 against a nonzero target.
    tick();
    mask = 8'hFF;
    count_en = 1'b1;
    for (int n = 0; n < 257; n++) send(W'($urandom_range(1, 255)), 1'b0);
    tick(); tick();
    count_en = 1'b0;
    @(negedge clk);
    check("sat_err",      32'(err_o[0]), 32'd255);
    check("sat_err_tog",  32'(err_o[1]), 32'd255);
    check("sat_err_nochk", 32'(err_o[2]), 32'd0);
    check("sat_pulses",   32'(mm_pulses), 32'd257);
    tick();
    mask = 8'h00;

    // Random traffic, occasional stuck bits and resets.
    for (int n = 0; n < 400; n++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      tgt_valid = $urandom_range(0, 1) == 1;
      tgt_data  = W'($urandom);
      mask      = ($urandom_range(0, 5) == 0) ? W'(1 << $urandom_range(0, W - 1)) : W'(0);
    end
    tick();
    rst = 1'b0; tgt_valid = 1'b0; mask = '0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
